// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: valid/ready request front end for a single-port synchronous
// RAM. It takes one read or write at a time, sequences cs/we/oe/addr and the
// shared data bus, and holds read data on a response channel until it is taken.
module sram_req_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        RSP     = 3'd4
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ready_q;
    logic                  cs_q;
    logic                  we_q;
    logic                  oe_q;

    // Controller FSM; the RAM strobes and req_ready are registered alongside
    // the state so they are always a pure function of the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wdata     <= '0;
            ram_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            ready_q   <= 1'b1;
            cs_q      <= 1'b0;
            we_q      <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        ram_addr <= req_addr;
                        wdata    <= req_wdata;
                        ready_q  <= 1'b0;
                        cs_q     <= 1'b1;
                        if (req_we) begin
                            state <= WR;
                            we_q  <= 1'b1;
                        end else begin
                            state <= RD_ADDR;
                        end
                    end
                end
                WR: begin
                    // RAM commits the write on this edge
                    state   <= IDLE;
                    cs_q    <= 1'b0;
                    we_q    <= 1'b0;
                    ready_q <= 1'b1;
                end
                RD_ADDR: begin
                    // RAM loads its output register on this edge
                    state <= RD_DATA;
                    oe_q  <= 1'b1;
                end
                RD_DATA: begin
                    state     <= RSP;
                    rsp_rdata <= ram_data;
                    rsp_valid <= 1'b1;
                    cs_q      <= 1'b0;
                    oe_q      <= 1'b0;
                end
                RSP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        ready_q   <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    ready_q   <= 1'b1;
                    cs_q      <= 1'b0;
                    we_q      <= 1'b0;
                    oe_q      <= 1'b0;
                end
            endcase
        end
    end

    // Reset must silence the RAM on the very edge it is sampled, so the strobes
    // are gated combinationally rather than waiting for the state to clear.
    assign req_ready = ready_q & ~rst;
    assign ram_cs    = cs_q & ~rst;
    assign ram_we    = we_q & ~rst;
    assign ram_oe    = oe_q & ~rst;

    // Drive the bus only while writing; the RAM owns it otherwise.
    assign ram_data  = ram_we ? wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Self-checking bench for sram_req_ctrl with a behavioural RAM on the bus and
// a flat array as the reference memory.
module tb_sram_req_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;
    logic          ram_cs;
    logic          ram_we;
    logic          ram_oe;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] exp_mem [16];
    time           t_acc;

    sram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
    );

    always #5 clk = ~clk;

    // Behavioural single-port synchronous RAM: registered read, output on oe.
    logic [DW-1:0] ram_mem [16];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) ram_mem[ram_addr] <= ram_data;
            else        ram_q <= ram_mem[ram_addr];
        end
    end
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_q : {DW{1'bz}};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus-safety and reset-quiet checks every cycle.
    always @(negedge clk) begin
        chk("we_oe_excl", 64'(ram_we & ram_oe), 64'd0);
        if (rst) chk("rst_quiet", 64'({ram_cs, ram_we, ram_oe, req_ready}), 64'd0);
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit keep);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        wait_ready();
        @(posedge clk); t_acc = $time; #1;
        if (!keep) req_valid = 1'b0;
        @(negedge clk);
        chk("wr_strobe", 64'({ram_cs, ram_we, ram_oe}), 64'b110);
        chk("wr_addr", 64'(ram_addr), 64'(a));
        chk("wr_bus", 64'(ram_data), 64'(d));
        chk("wr_busy", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("wr_done", 64'({ram_cs, ram_we, req_ready}), 64'b001);
        exp_mem[a] = d;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int hold);
        logic [DW-1:0] held;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        wait_ready();
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rd_c1", 64'({ram_cs, ram_we, ram_oe, rsp_valid}), 64'b1000);
        @(negedge clk);
        chk("rd_c2", 64'({ram_cs, ram_we, ram_oe, rsp_valid}), 64'b1010);
        @(negedge clk);
        chk("rd_c3", 64'({ram_cs, ram_oe, rsp_valid, req_ready}), 64'b0010);
        chk("rd_data", 64'(rsp_rdata), 64'(exp_mem[a]));
        held = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rsp_hold", 64'({rsp_valid, req_ready}), 64'b10);
            chk("rsp_stable", 64'(rsp_rdata), 64'(held));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("rsp_release", 64'({rsp_valid, req_ready}), 64'b01);
    endtask

    initial begin
        time t_prev;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp", 64'({rsp_valid, rsp_rdata}), 64'd0);
        chk("rst_addr", 64'(ram_addr), 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 64'(req_ready), 64'd1);

        // 1: write then read back
        do_write(4'd3, 32'hDEADBEEF, 1'b0);
        do_read(4'd3, 0);

        // 2: back-to-back writes with req_valid held, then read all
        for (int i = 0; i < 16; i++) begin
            do_write(4'(i), 32'(i) * 32'h11111111, 1'b1);
            if (i > 0) chk("b2b_spacing", 64'(t_acc - t_prev), 64'd20);
            t_prev = t_acc;
        end
        req_valid = 1'b0;
        for (int i = 0; i < 16; i++) do_read(4'(i), 0);

        // 3: read with consumer stalled for 6 cycles
        do_read(4'd5, 6);

        // 4a: reset during RD_DATA drops the read
        do_write(4'd7, 32'hA5A5A5A5, 1'b0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd7;
        wait_ready();
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        chk("rst_rd_oe", 64'(ram_oe), 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_rd_norsp", 64'({rsp_valid, req_ready}), 64'b01);
        end
        chk("rst_rd_clear", 64'({ram_addr, rsp_rdata}), 64'd0);

        // 4b: reset during WR suppresses the write
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd7; req_wdata = 32'h12345678;
        wait_ready();
        @(posedge clk); #1; req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_wr_we", 64'({ram_cs, ram_we}), 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("rst_wr_idle", 64'(req_ready), 64'd1);
        do_read(4'd7, 0);

        // Randomised mix against the reference memory
        for (int k = 0; k < 40; k++) begin
            logic [AW-1:0] a;
            a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 1'b0);
            else                           do_read(a, int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
